// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 request port between the icache and
// dcache controllers. One requester owns the port for a whole block
// transaction. Beats are steered back to that owner, and ownership passes
// round-robin when both controllers are asking.

package l2_port_arbiter_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int XLEN            = 32,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_address,
  output logic                  ic_grant,
  output logic                  ic_fetched_word_valid,
  input  logic                  dc_req_valid,
  input  memory_operation_e     dc_req_type,
  input  logic [ADDR_WIDTH-1:0] dc_req_address,
  input  logic [XLEN-1:0]       dc_store_word,
  output logic                  dc_grant,
  output logic                  dc_fetched_word_valid,
  output logic                  dc_store_word_ack,
  output logic                  l2_req_valid,
  output memory_operation_e     l2_req_type,
  output logic [ADDR_WIDTH-1:0] l2_req_address,
  output logic [XLEN-1:0]       l2_store_word,
  input  logic                  l2_fetched_word_valid,
  input  logic                  l2_store_word_ack
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT_IC, ST_GRANT_DC} state_e;
  typedef enum logic {OWNER_IC, OWNER_DC} owner_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  memory_operation_e     type_q, type_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  owner_e                last_grant_q, last_grant_d;

  logic owner_valid;
  logic load_beat;
  logic store_beat;
  logic beat;

  // The owner must still be asserting valid for its beats to count; a dropped
  // valid is treated as an abort, so any beat in that cycle is discarded.
  assign owner_valid = ((state_q == ST_GRANT_IC) && ic_req_valid) ||
                       ((state_q == ST_GRANT_DC) && dc_req_valid);
  assign load_beat   = owner_valid && (type_q == LOAD)  && l2_fetched_word_valid;
  assign store_beat  = owner_valid && (type_q == STORE) && l2_store_word_ack;
  assign beat        = load_beat || store_beat;

  // State register: FSM state, beat counter, latched request and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      type_q       <= LOAD;
      address_q    <= '0;
      last_grant_q <= OWNER_IC;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      type_q       <= type_d;
      address_q    <= address_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic: arbitrate in idle, count beats down while granted.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    type_d       = type_q;
    address_d    = address_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dc_req_valid && (!ic_req_valid || (last_grant_q == OWNER_IC))) begin
          state_d      = ST_GRANT_DC;
          type_d       = dc_req_type;
          address_d    = dc_req_address;
          count_d      = LAST_BEAT;
          last_grant_d = OWNER_DC;
        end else if (ic_req_valid) begin
          state_d      = ST_GRANT_IC;
          type_d       = LOAD;
          address_d    = ic_req_address;
          count_d      = LAST_BEAT;
          last_grant_d = OWNER_IC;
        end
      end
      ST_GRANT_IC, ST_GRANT_DC: begin
        if (!owner_valid) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (beat) begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs: grants decode the state, beat strobes go only to the current owner.
  always_comb begin
    ic_grant              = (state_q == ST_GRANT_IC);
    dc_grant              = (state_q == ST_GRANT_DC);
    l2_req_valid          = (state_q != ST_IDLE);
    ic_fetched_word_valid = load_beat  && (state_q == ST_GRANT_IC);
    dc_fetched_word_valid = load_beat  && (state_q == ST_GRANT_DC);
    dc_store_word_ack     = store_beat && (state_q == ST_GRANT_DC);
    l2_req_type           = type_q;
    l2_req_address        = address_q;
    l2_store_word         = (state_q == ST_GRANT_DC) ? dc_store_word : '0;
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: scenario tasks drive one row per clock and push the
// expected outputs for that row into a scoreboard, which is popped and
// compared mid-cycle.

module tb_l2_port_arbiter;
  import l2_port_arbiter_pkg::*;

  // Flag vector order: {ic_grant, dc_grant, l2_req_valid, ic_fv, dc_fv, dc_ack}
  localparam logic [5:0] F_IDLE = 6'b000000;
  localparam logic [5:0] F_GIC  = 6'b101000;
  localparam logic [5:0] F_GDC  = 6'b011000;
  localparam logic [5:0] F_IFV  = 6'b000100;
  localparam logic [5:0] F_DFV  = 6'b000010;
  localparam logic [5:0] F_DACK = 6'b000001;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ic_req_valid = 1'b0;
  logic [31:0]       ic_req_address = '0;
  logic              ic_grant;
  logic              ic_fetched_word_valid;
  logic              dc_req_valid = 1'b0;
  memory_operation_e dc_req_type = LOAD;
  logic [31:0]       dc_req_address = '0;
  logic [31:0]       dc_store_word = '0;
  logic              dc_grant;
  logic              dc_fetched_word_valid;
  logic              dc_store_word_ack;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [31:0]       l2_req_address;
  logic [31:0]       l2_store_word;
  logic              l2_fetched_word_valid = 1'b0;
  logic              l2_store_word_ack = 1'b0;

  typedef struct {
    logic              rst;
    logic              icv;
    logic [31:0]       ica;
    logic              dcv;
    memory_operation_e dct;
    logic [31:0]       dca;
    logic [31:0]       sw;
    logic              fv;
    logic              ack;
    logic [5:0]        ef;
    logic              echk;
    memory_operation_e etyp;
    logic [31:0]       eaddr;
  } row_t;

  typedef struct {
    logic [5:0]        flags;
    logic              chk;
    memory_operation_e typ;
    logic [31:0]       addr;
    logic [31:0]       sw;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  l2_port_arbiter #(
    .ADDR_WIDTH(32),
    .XLEN(32),
    .WORDS_PER_BLOCK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ic_req_valid(ic_req_valid),
    .ic_req_address(ic_req_address),
    .ic_grant(ic_grant),
    .ic_fetched_word_valid(ic_fetched_word_valid),
    .dc_req_valid(dc_req_valid),
    .dc_req_type(dc_req_type),
    .dc_req_address(dc_req_address),
    .dc_store_word(dc_store_word),
    .dc_grant(dc_grant),
    .dc_fetched_word_valid(dc_fetched_word_valid),
    .dc_store_word_ack(dc_store_word_ack),
    .l2_req_valid(l2_req_valid),
    .l2_req_type(l2_req_type),
    .l2_req_address(l2_req_address),
    .l2_store_word(l2_store_word),
    .l2_fetched_word_valid(l2_fetched_word_valid),
    .l2_store_word_ack(l2_store_word_ack)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic row_t mk(input logic rst, input logic icv, input logic [31:0] ica,
                              input logic dcv, input memory_operation_e dct, input logic [31:0] dca,
                              input logic [31:0] sw, input logic fv, input logic ack,
                              input logic [5:0] ef, input logic echk,
                              input memory_operation_e etyp, input logic [31:0] eaddr);
    row_t r;
    r.rst = rst; r.icv = icv; r.ica = ica; r.dcv = dcv; r.dct = dct; r.dca = dca;
    r.sw = sw; r.fv = fv; r.ack = ack; r.ef = ef; r.echk = echk; r.etyp = etyp; r.eaddr = eaddr;
    return r;
  endfunction

  function automatic logic [5:0] obs_flags();
    return {ic_grant, dc_grant, l2_req_valid, ic_fetched_word_valid,
            dc_fetched_word_valid, dc_store_word_ack};
  endfunction

  // Drive one row just after the rising edge, record its expectation, wait to mid-cycle.
  task automatic drive(input row_t r);
    exp_t e;
    @(posedge clk);
    #1;
    reset                 = r.rst;
    ic_req_valid          = r.icv;
    ic_req_address        = r.ica;
    dc_req_valid          = r.dcv;
    dc_req_type           = r.dct;
    dc_req_address        = r.dca;
    dc_store_word         = r.sw;
    l2_fetched_word_valid = r.fv;
    l2_store_word_ack     = r.ack;
    e.flags = r.ef;
    e.chk   = r.echk;
    e.typ   = r.etyp;
    e.addr  = r.eaddr;
    e.sw    = r.ef[4] ? r.sw : 32'h0;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, LOAD, 0, 32'h0,    1, 1, F_IDLE, 1, LOAD, 0));
    rows.push_back(mk(0, 0, 0, 0, LOAD, 0, 32'hCAFE, 1, 1, F_IDLE, 1, LOAD, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_flags() !== e.flags || l2_store_word !== e.sw ||
          (e.chk && (l2_req_type !== e.typ || l2_req_address !== e.addr))) begin
        miscompares++;
        $display("[TB] FAIL reset[%0d]: got flags=%b type=%0d addr=%h sw=%h, want flags=%b type=%0d addr=%h sw=%h",
                 i, obs_flags(), l2_req_type, l2_req_address, l2_store_word, e.flags, e.typ, e.addr, e.sw);
      end
    end
  endtask

  task automatic test_dc_load();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h1000,     0, 0, 0, F_IDLE,        0, LOAD, 0));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h1000,     0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h1000));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'hBEEF0000, 0, 0, 1, F_GDC,         1, LOAD, 32'h1000));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'hBEEF0000, 0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h1000));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h1000,     0, 0, 0, F_GDC,         1, LOAD, 32'h1000));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h1000,     0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h1000));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h1000,     0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h1000));
    rows.push_back(mk(0, 0, 0, 0, LOAD,  32'h1000,     0, 0, 0, F_IDLE,        0, LOAD, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_flags() !== e.flags || l2_store_word !== e.sw ||
          (e.chk && (l2_req_type !== e.typ || l2_req_address !== e.addr))) begin
        miscompares++;
        $display("[TB] FAIL dc_load[%0d]: got flags=%b type=%0d addr=%h sw=%h, want flags=%b type=%0d addr=%h sw=%h",
                 i, obs_flags(), l2_req_type, l2_req_address, l2_store_word, e.flags, e.typ, e.addr, e.sw);
      end
    end
  endtask

  task automatic test_dc_store_then_load();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'h2040, 32'h11111111, 0, 1, F_IDLE,         0, LOAD,  0));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'h2040, 32'hA0,       0, 1, F_GDC | F_DACK, 1, STORE, 32'h2040));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'h2040, 32'hA1,       1, 0, F_GDC,          1, STORE, 32'h2040));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'h2040, 32'hA1,       0, 1, F_GDC | F_DACK, 1, STORE, 32'h2040));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'h2040, 32'hA2,       0, 1, F_GDC | F_DACK, 1, STORE, 32'h2040));
    rows.push_back(mk(0, 0, 0, 1, STORE, 32'h2040, 32'hA3,       0, 1, F_GDC | F_DACK, 1, STORE, 32'h2040));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h2040, 32'hA3,       0, 1, F_IDLE,         0, LOAD,  0));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h2040, 32'h0,        1, 0, F_GDC | F_DFV,  1, LOAD,  32'h2040));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h2040, 32'h0,        1, 0, F_GDC | F_DFV,  1, LOAD,  32'h2040));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h2040, 32'h0,        1, 0, F_GDC | F_DFV,  1, LOAD,  32'h2040));
    rows.push_back(mk(0, 0, 0, 1, LOAD,  32'h2040, 32'h0,        1, 0, F_GDC | F_DFV,  1, LOAD,  32'h2040));
    rows.push_back(mk(0, 0, 0, 0, LOAD,  32'h2040, 32'h0,        0, 0, F_IDLE,         0, LOAD,  0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_flags() !== e.flags || l2_store_word !== e.sw ||
          (e.chk && (l2_req_type !== e.typ || l2_req_address !== e.addr))) begin
        miscompares++;
        $display("[TB] FAIL dc_store_load[%0d]: got flags=%b type=%0d addr=%h sw=%h, want flags=%b type=%0d addr=%h sw=%h",
                 i, obs_flags(), l2_req_type, l2_req_address, l2_store_word, e.flags, e.typ, e.addr, e.sw);
      end
    end
  endtask

  task automatic test_conflict();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0,        0, LOAD, 0,        0, 0, 0, F_IDLE,        0, LOAD, 0));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 0, 0, F_IDLE,        1, LOAD, 0));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h4000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h4000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h4000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GDC | F_DFV, 1, LOAD, 32'h4000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 0, 0, F_IDLE,        0, LOAD, 0));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h3000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 0, 1, F_GIC,         1, LOAD, 32'h3000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h3000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h3000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h3000));
    rows.push_back(mk(0, 1, 32'h3000, 1, LOAD, 32'h4000, 0, 0, 0, F_IDLE,        0, LOAD, 0));
    rows.push_back(mk(0, 0, 32'h3000, 0, LOAD, 32'h4000, 0, 0, 0, F_GDC,         1, LOAD, 32'h4000));
    rows.push_back(mk(0, 0, 32'h3000, 0, LOAD, 32'h4000, 0, 0, 0, F_IDLE,        0, LOAD, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_flags() !== e.flags || l2_store_word !== e.sw ||
          (e.chk && (l2_req_type !== e.typ || l2_req_address !== e.addr))) begin
        miscompares++;
        $display("[TB] FAIL conflict[%0d]: got flags=%b type=%0d addr=%h sw=%h, want flags=%b type=%0d addr=%h sw=%h",
                 i, obs_flags(), l2_req_type, l2_req_address, l2_store_word, e.flags, e.typ, e.addr, e.sw);
      end
    end
  endtask

  task automatic test_abort();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, 0,        1, STORE, 32'h5000, 32'hB0, 0, 0, F_IDLE,         0, LOAD,  0));
    rows.push_back(mk(0, 1, 32'h6000, 1, STORE, 32'h5000, 32'hB1, 0, 1, F_GDC | F_DACK, 1, STORE, 32'h5000));
    rows.push_back(mk(0, 1, 32'h6000, 1, STORE, 32'h5000, 32'hB2, 0, 1, F_GDC | F_DACK, 1, STORE, 32'h5000));
    rows.push_back(mk(0, 1, 32'h6000, 0, STORE, 32'h5000, 32'hB3, 0, 1, F_GDC,          1, STORE, 32'h5000));
    rows.push_back(mk(0, 1, 32'h6000, 0, STORE, 32'h5000, 32'h0,  0, 0, F_IDLE,         0, LOAD,  0));
    rows.push_back(mk(0, 1, 32'h6000, 0, LOAD,  0,        32'hDD, 1, 0, F_GIC | F_IFV,  1, LOAD,  32'h6000));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_flags() !== e.flags || l2_store_word !== e.sw ||
          (e.chk && (l2_req_type !== e.typ || l2_req_address !== e.addr))) begin
        miscompares++;
        $display("[TB] FAIL abort[%0d]: got flags=%b type=%0d addr=%h sw=%h, want flags=%b type=%0d addr=%h sw=%h",
                 i, obs_flags(), l2_req_type, l2_req_address, l2_store_word, e.flags, e.typ, e.addr, e.sw);
      end
    end
  endtask

  task automatic test_reset_mid_transaction();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, 32'h6000, 0, LOAD, 0, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h6000));
    rows.push_back(mk(1, 1, 32'h6000, 0, LOAD, 0, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h6000));
    rows.push_back(mk(0, 1, 32'h7000, 0, LOAD, 0, 0, 1, 1, F_IDLE,        1, LOAD, 0));
    rows.push_back(mk(0, 1, 32'h7000, 0, LOAD, 0, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h7000));
    rows.push_back(mk(0, 1, 32'h7000, 0, LOAD, 0, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h7000));
    rows.push_back(mk(0, 1, 32'h7000, 0, LOAD, 0, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h7000));
    rows.push_back(mk(0, 1, 32'h7000, 0, LOAD, 0, 0, 1, 0, F_GIC | F_IFV, 1, LOAD, 32'h7000));
    rows.push_back(mk(0, 0, 32'h7000, 0, LOAD, 0, 0, 0, 0, F_IDLE,        0, LOAD, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_flags() !== e.flags || l2_store_word !== e.sw ||
          (e.chk && (l2_req_type !== e.typ || l2_req_address !== e.addr))) begin
        miscompares++;
        $display("[TB] FAIL reset_mid[%0d]: got flags=%b type=%0d addr=%h sw=%h, want flags=%b type=%0d addr=%h sw=%h",
                 i, obs_flags(), l2_req_type, l2_req_address, l2_store_word, e.flags, e.typ, e.addr, e.sw);
      end
    end
  endtask

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_dc_load();
    test_dc_store_then_load();
    test_conflict();
    test_abort();
    test_reset_mid_transaction();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 request port between the instruction-cache and data-cache controllers.
- Grants one requester at a time for one whole block transaction of WORDS_PER_BLOCK beats.
- Latches that requester's address and operation, steers per-word beat strobes back to the granted requester, and re-arbitrates round-robin.
- Supplies the per-word store acknowledge the data-cache controller needs in its flush state.

Parameters:
ADDR_WIDTH, 32, width of the block address.
XLEN, 32, width of one data word.
WORDS_PER_BLOCK, 4, beats per transaction; power of two, ≥2.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ic_req_valid  input  1  icache requests a block load; held high for the whole transaction
ic_req_address  input  ADDR_WIDTH  icache block address
ic_grant  output  1  icache currently owns the L2 port
ic_fetched_word_valid  output  1  load beat for icache
dc_req_valid  input  1  dcache requests a block transaction; held high for the whole transaction
dc_req_type  input  memory_operation_e  LOAD or STORE
dc_req_address  input  ADDR_WIDTH  dcache block address
dc_store_word  input  XLEN  current dcache flush word
dc_grant  output  1  dcache currently owns the L2 port
dc_fetched_word_valid  output  1  load beat for dcache
dc_store_word_ack  output  1  store beat accepted by L2
l2_req_valid  output  1  request to L2
l2_req_type  output  memory_operation_e  latched operation
l2_req_address  output  ADDR_WIDTH  latched block address
l2_store_word  output  XLEN  store data toward L2
l2_fetched_word_valid  input  1  L2 returns one load word
l2_store_word_ack  input  1  L2 accepted one store word

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- States: ST_IDLE, ST_GRANT_IC, ST_GRANT_DC. Registers: state, beat counter, latched type and address, last_grant pointer.
- Reset:
  - state ST_IDLE, counter 0, last_grant = IC (dcache wins the first conflict).
  - All 1-bit outputs 0, l2_req_type LOAD, l2_req_address 0.
- ST_IDLE:
  - Only dc_req_valid → ST_GRANT_DC. Only ic_req_valid → ST_GRANT_IC.
  - Both valid → grant the requester that is not last_grant.
  - On any grant: latch address and type (IC type is always LOAD), load counter = WORDS_PER_BLOCK-1, update last_grant.
  - Beat or ack inputs arriving in IDLE are ignored and not forwarded.
- Latency: request seen in cycle N → grant, l2_req_valid and latched fields visible in N+1. Grant outputs are Moore (decoded from state).
- Granted states:
  - l2_req_valid = 1 and grant = 1 for the owner; l2_req_type and l2_req_address come from the latches.
  - A mid-transaction change on the requester's address or type inputs is ignored.
- Beat definition:
  - Latched LOAD: beat = l2_fetched_word_valid, forwarded the same cycle to the owner's fetched_word_valid.
  - Latched STORE: beat = l2_store_word_ack, forwarded the same cycle to dc_store_word_ack.
  - Cross-type strobe (e.g. store ack during a LOAD transaction) is ignored.
  - Non-owner strobes are always 0.
- l2_store_word = dc_store_word, combinational pass-through; 0 when the dcache does not own the port.
- Counter:
  - Decrements by 1 on each beat.
  - A beat with counter == 0 is the last beat → next state ST_IDLE, counter 0.
  - No wrap-around below 0.
- Back-to-back: after the last beat the arbiter spends exactly one cycle in ST_IDLE (l2_req_valid = 0), then re-arbitrates.
  - A requester still holding valid (e.g. dcache going FLUSH→LOAD) starts a new transaction with a freshly latched type.
- Abort: if the owner deasserts req_valid while granted:
  - Next state ST_IDLE, counter cleared.
  - Any beat in that cycle is not forwarded.
  - last_grant keeps the aborted owner.
- Reset asserted mid-transaction: all of the above returns to reset values the next cycle; in-flight beats are dropped.

Test Plan:
- Single dcache LOAD, addr 0x1000, 4 fetched-valid pulses with gaps → dc_grant high cycles 1..last, dc_fetched_word_valid mirrors all 4 pulses, l2_req_valid drops the cycle after the 4th.
- Dcache STORE flush, addr 0x2040, dc_store_word changes per ack → 4 dc_store_word_ack pulses, l2_store_word tracks input, then one idle cycle, then a LOAD re-grant to dcache at the same address.
- ic and dc assert valid in the same cycle after reset → dcache granted first; icache granted after one idle cycle; with both still requesting, grants alternate dc, ic, dc.
- Strobes: l2_store_word_ack during an icache LOAD grant → no output pulse; l2_fetched_word_valid in ST_IDLE → no output pulse, counter unchanged.
- Dcache drops valid after 2 beats → IDLE next cycle, the same-cycle beat is not forwarded, and a pending icache request is granted next.
- Reset pulse during beat 3 of an icache load → all outputs 0 next cycle, l2_req_type LOAD; a fresh request completes 4 full beats.
